// File: rtl/du_ram_if.sv
// rtl/du_ram_if.sv - dual-port RAM access bundle for ports A and B
interface du_ram_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6
);
    logic [DATA_WIDTH-1:0] data_a;
    logic                  wren_a;
    logic [ADDR_WIDTH-1:0] address_a;
    logic [DATA_WIDTH-1:0] q_a;
    logic [DATA_WIDTH-1:0] data_b;
    logic                  wren_b;
    logic [ADDR_WIDTH-1:0] address_b;
    logic [DATA_WIDTH-1:0] q_b;

    modport master (
        output data_a, wren_a, address_a,
        output data_b, wren_b, address_b,
        input  q_a, q_b
    );

    modport slave (
        input  data_a, wren_a, address_a,
        input  data_b, wren_b, address_b,
        output q_a, q_b
    );
endinterface

// File: rtl/du_ram.sv
// rtl/du_ram.sv - true dual-port RAM, read-first, port A wins dual writes; DU_RAM_FWD_EN enables cross-port forwarding
module du_ram #(
    parameter int    DATA_WIDTH = 32,
    parameter int    ADDR_WIDTH = 6,
    parameter string BLK_TYPE   = "auto"
) (
    input logic  Clk,
    input logic  Reset,
    du_ram_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    // BLK_TYPE only steers the RAM-style hint; both branches are functionally identical.
    if (BLK_TYPE == "auto") begin : g_mem
        logic [DATA_WIDTH-1:0] mem [DEPTH];
    end else begin : g_mem
        (* ram_style = BLK_TYPE *) logic [DATA_WIDTH-1:0] mem [DEPTH];
    end

    logic [DATA_WIDTH-1:0] nxt_q_a;
    logic [DATA_WIDTH-1:0] nxt_q_b;

    // Read-side selection: pre-write contents, optionally replaced by the other port's write data.
    always_comb begin
        nxt_q_a = g_mem.mem[bus.address_a];
        nxt_q_b = g_mem.mem[bus.address_b];
`ifdef DU_RAM_FWD_EN
        // A port that is itself writing reads its own write address and stays read-first.
        if (bus.wren_b && !bus.wren_a && (bus.address_b == bus.address_a)) begin
            nxt_q_a = bus.data_b;
        end
        if (bus.wren_a && !bus.wren_b && (bus.address_a == bus.address_b)) begin
            nxt_q_b = bus.data_a;
        end
`endif
    end

    // Memory writes; port A is applied last so it wins a same-address dual write.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            if (bus.wren_b) begin
                g_mem.mem[bus.address_b] <= bus.data_b;
            end
            if (bus.wren_a) begin
                g_mem.mem[bus.address_a] <= bus.data_a;
            end
        end
    end

    // Output registers update on every edge and clear as soon as Reset rises.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            bus.q_a <= '0;
            bus.q_b <= '0;
        end else begin
            bus.q_a <= nxt_q_a;
            bus.q_b <= nxt_q_b;
        end
    end
endmodule

// File: tb/tb_du_ram.sv
// tb/tb_du_ram.sv - directed self-checking bench for du_ram
module tb_du_ram;
    localparam int DW = 32;
    localparam int AW = 6;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_bad;

    du_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    du_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLK_TYPE("auto")) dut (
        .Clk   (clk),
        .Reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_ne(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] bad);
        n_vec++;
        assert (obs !== bad) else begin
            n_bad++;
            $error("FAIL %s: observed %h must differ from %h", tag, obs, bad);
        end
    endtask

    task automatic idle();
        bus.wren_a = 1'b0;
        bus.wren_b = 1'b0;
        bus.data_a = '0;
        bus.data_b = '0;
    endtask

    logic [DW-1:0] exp_coll;
    logic [DW-1:0] v;

    initial begin
        n_vec = 0;
        n_bad = 0;
`ifdef DU_RAM_FWD_EN
        exp_coll = 32'h5555_5555;
`else
        exp_coll = 32'hAAAA_AAAA;
`endif
        // Reset held with a pending write on port A
        reset         = 1'b1;
        bus.wren_a    = 1'b1;
        bus.data_a    = 32'hDEAD_BEEF;
        bus.address_a = 6'd3;
        bus.wren_b    = 1'b0;
        bus.data_b    = '0;
        bus.address_b = 6'd3;
        tick();
        tick();
        chk("reset_q_a", bus.q_a, '0);
        chk("reset_q_b", bus.q_b, '0);

        reset = 1'b0;
        idle();
        tick();
        chk_ne("reset_nowrite_a", bus.q_a, 32'hDEAD_BEEF);
        chk_ne("reset_nowrite_b", bus.q_b, 32'hDEAD_BEEF);

        // Same-port read-first on address 7
        bus.wren_a = 1'b1; bus.data_a = 32'h1111_1111; bus.address_a = 6'd7;
        bus.address_b = 6'd0;
        tick();
        bus.data_a = 32'h2222_2222;
        tick();
        chk("rfirst_old", bus.q_a, 32'h1111_1111);
        idle();
        tick();
        chk("rfirst_new", bus.q_a, 32'h2222_2222);

        // A writes address 5 at edge k, B reads it at k+1
        bus.wren_a = 1'b1; bus.data_a = 32'h1234_5678; bus.address_a = 6'd5;
        bus.address_b = 6'd7;
        tick();
        chk("lat_b_pre", bus.q_b, 32'h2222_2222);
        idle();
        bus.address_b = 6'd5;
        tick();
        chk("lat_b_k1", bus.q_b, 32'h1234_5678);
        bus.address_b = 6'd7;
        tick();
        chk("lat_b_next", bus.q_b, 32'h2222_2222);

        // Cross-port collision on address 9 (initial write through port B)
        bus.wren_b = 1'b1; bus.data_b = 32'hAAAA_AAAA; bus.address_b = 6'd9;
        tick();
        bus.wren_b = 1'b0; bus.data_b = '0;
        bus.wren_a = 1'b1; bus.data_a = 32'h5555_5555; bus.address_a = 6'd9;
        tick();
        chk("coll_q_b", bus.q_b, exp_coll);
        chk("coll_q_a_rfirst", bus.q_a, 32'hAAAA_AAAA);
        idle();
        tick();
        chk("coll_after_a", bus.q_a, 32'h5555_5555);
        chk("coll_after_b", bus.q_b, 32'h5555_5555);

        // Dual write to address 63: both read old data, A's data is kept
        bus.wren_a = 1'b1; bus.data_a = 32'h0000_CAFE; bus.address_a = 6'd63;
        tick();
        bus.data_a = 32'h1; bus.address_a = 6'd63;
        bus.wren_b = 1'b1; bus.data_b = 32'h2; bus.address_b = 6'd63;
        tick();
        chk("dual_old_a", bus.q_a, 32'h0000_CAFE);
        chk("dual_old_b", bus.q_b, 32'h0000_CAFE);
        idle();
        tick();
        chk("dual_kept_a", bus.q_a, 32'h1);
        chk("dual_kept_b", bus.q_b, 32'h1);

        // Mid-cycle reset clears q without an edge and aborts the pending write
        bus.wren_a = 1'b1; bus.data_a = 32'h0000_0BAD; bus.address_a = 6'd63;
        #2;
        reset = 1'b1;
        #1;
        chk("async_clr_a", bus.q_a, '0);
        chk("async_clr_b", bus.q_b, '0);
        tick();
        chk("rst_hold_a", bus.q_a, '0);
        reset = 1'b0;
        idle();
        tick();
        chk("abort_write", bus.q_a, 32'h1);

        // Full sweep: even addresses via A, odd via B
        for (int i = 0; i < 64; i++) begin
            v = i * 32'h0101_0101;
            idle();
            if (i % 2 == 0) begin
                bus.wren_a = 1'b1; bus.data_a = v; bus.address_a = i[AW-1:0];
                bus.address_b = 6'd0;
            end else begin
                bus.wren_b = 1'b1; bus.data_b = v; bus.address_b = i[AW-1:0];
                bus.address_a = 6'd1;
            end
            tick();
        end
        idle();
        for (int i = 0; i < 64; i++) begin
            bus.address_a = i[AW-1:0];
            bus.address_b = 6'(63 - i);
            tick();
            v = i * 32'h0101_0101;
            chk($sformatf("sweep_a[%0d]", i), bus.q_a, v);
            v = (63 - i) * 32'h0101_0101;
            chk($sformatf("sweep_b[%0d]", 63 - i), bus.q_b, v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/du_ram.md
# du_ram

Synchronous true dual-port RAM, 2^ADDR_WIDTH words of DATA_WIDTH bits, with two independent read/write ports on a single clock. Used by the RMON statistics block: port A for counter read-modify-write, port B as the CPU read port. Both ports have registered outputs with one-cycle read latency. The same-address collision behaviour is fixed and does not depend on the inferred memory primitive.

## Interface
- DATA_WIDTH, 32, word width in bits
- ADDR_WIDTH, 6, address width; depth = 2^ADDR_WIDTH (64 words)
- BLK_TYPE, "auto", synthesis RAM-style hint only; no functional effect
- Clk  input  1  single clock for both ports, rising-edge active
- Reset  input  1  asynchronous, active-high reset
- data_a  input  DATA_WIDTH  port A write data
- wren_a  input  1  port A write enable
- address_a  input  ADDR_WIDTH  port A address
- q_a  output  DATA_WIDTH  port A registered read data
- data_b  input  DATA_WIDTH  port B write data
- wren_b  input  1  port B write enable
- address_b  input  ADDR_WIDTH  port B address
- q_b  output  DATA_WIDTH  port B registered read data

## Operation
- Each rising Clk edge with Reset low, each port independently does the following:
  - Reads the word at its address into its q register.
  - If its wren is 1, writes its data into that address.
- Same-port read-during-write is read-first: q gets the old word. The new word is visible on the next read of that address.
- Cross-port read-during-write (port X writes address N while port Y reads address N in the same cycle): Y's q gets the old word, unless DU_RAM_FWD_EN is defined (see Configuration).
- Both ports write the same address in the same cycle: port A's data is stored and port B's write is discarded.
- Reset behaviour:
  - Reset asserted clears q_a and q_b to 0 immediately, with no clock required.
  - While Reset is high, writes are ignored and q stays 0.
  - Memory contents are not cleared by Reset. Contents at power-up are undefined; the user must initialise them by writing.
- Addresses always fall within depth, so there is no out-of-range case.
- The port B write path must be fully functional even when a port is tied off with wren_b=0 and data_b=0.

## Timing
- Read latency is 1 cycle. Address presented before edge k gives data on q after edge k, valid for the whole cycle k→k+1.
- A write at edge k is readable by either port at edge k+1, so it appears on q after k+1.
- q holds its value unless a new edge updates it. Every edge updates q, even when the port is idle.
- Reset deassertion is synchronous to Clk by the caller. The first access takes effect on the first rising edge with Reset low.
- Reset asserted mid-cycle aborts any write at the next edge, and q clears immediately.

## Configuration
- DU_RAM_FWD_EN defined: cross-port collision forwarding.
  - If the other port writes address N at edge k while this port reads N, this port's q gets the newly written data after edge k.
  - When both ports write, a port reading its own write address still returns old data (read-first).
- DU_RAM_FWD_EN undefined: collisions return the pre-write contents, as stated in Operation. No forwarding logic is generated.

## Test plan
- Reset: hold Reset=1 with wren_a=1, data_a=0xDEADBEEF, address_a=3 → q_a=q_b=0. After release, a read of address 3 does not return 0xDEADBEEF.
- A-write / B-read: write 0x12345678 to address 5 via A at edge k; B reads address 5 at edge k+1 → q_b=0x12345678 after k+1. Latency is exactly 1 cycle.
- Same-port read-first: address 7 holds 0x11111111; A writes 0x22222222 to address 7 → q_a=0x11111111 that edge, 0x22222222 on the next edge.
- Cross-port collision: address 9 holds 0xAAAAAAAA; A writes 0x55555555 to address 9 while B reads 9 → q_b=0xAAAAAAAA without the macro, 0x55555555 with DU_RAM_FWD_EN.
- Dual write same address: A writes 0x1 and B writes 0x2 to address 63 → a subsequent read returns 0x1.
- Full sweep: write address i with value i*0x01010101 for i=0..63 via A, then via B alternately. Read back on both ports → all 64 values match, including address 0 and address 63.
